armleocpu_regfile_mp: RTL and testbench
=======================================

Name: armleocpu_regfile_mp

Overview:
Parametrised multi-read-port integer register file, successor to the fixed 32x32 two-read-port file. It is generalised in data width, register count and read-port count. It adds write-to-read bypass, a hardwired-zero option, and a sequential clear engine that zeroes storage one entry per cycle after reset or on request. It sits between decode (reads) and writeback (single write port), and stalls the core through busy while clearing.

Parameters:
DATA_WIDTH, 32, bits per register
REG_COUNT, 32, number of registers (power of two, >=2)
READ_PORTS, 2, number of independent combinational read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
clear_req  in  1  pulse: restart the clear engine (honoured only when not busy)
busy  out  1  clear engine active; writes ignored, reads return 0
rs_addr  in  READ_PORTS*AW  packed read addresses, port k at [k*AW +: AW], AW=$clog2(REG_COUNT)
rs_rdata  out  READ_PORTS*DATA_WIDTH  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
rd_addr  in  AW  write address
rd_wdata  in  DATA_WIDTH  write data
rd_write  in  1  write enable

Behaviour:
- Reset: rst high -> FSM=CLEAR, clear_cnt=0, busy=1, rs_rdata=0. Storage is not reset directly.
- FSM CLEAR, each clk: regs[clear_cnt]<=0, clear_cnt++. When clear_cnt==REG_COUNT-1 -> READY, and clear_cnt wraps to 0.
- Clearing takes exactly REG_COUNT cycles after rst falls; busy drops at the edge that writes the last entry.
- FSM READY: clear_req=1 -> CLEAR on the next edge; busy is 1 from the following cycle.
- clear_req while in CLEAR is ignored; there is no restart.
- rst asserted mid-clear -> FSM=CLEAR, clear_cnt=0 immediately; the full clear restarts after release.
- Write (READY only): rd_write=1 and !(ZERO_REG && rd_addr==0) -> regs[rd_addr]<=rd_wdata at the rising edge. rd_write while busy is dropped silently.
- Read, per port, combinational, zero latency. Priority order:
  1. busy -> 0
  2. ZERO_REG && addr==0 -> 0
  3. BYPASS && rd_write && rd_addr==addr -> rd_wdata
  4. otherwise regs[addr]
- Multiple ports on the same address return identical data.
- BYPASS=0: the new value is visible from the cycle after the write edge.
- Out-of-range addresses cannot occur (power-of-two REG_COUNT).

Optional Feature:
Macro ARMLEOCPU_REGFILE_PARITY_EN.
- Defined: each entry stores an even-parity bit computed from rd_wdata on write; the clear engine writes parity 0.
- Defined: adds input rd_parity_flip (1), which inverts the stored parity bit of the write in progress (for error injection).
- Defined: adds output rs_parity_err (READY ONLY, READ_PORTS): bit k = parity mismatch of regs[rs_addr[k]]. It is forced 0 when the read is bypassed, zero-reg, or busy.
- Not defined: no parity storage, no extra ports, identical timing.

Decomposition:
- Package armleocpu_regfile_pkg holds:
  - FSM state enum (STATE_CLEAR, STATE_READY)
  - function for AW computation
  - parity helper function
- One natural sub-module, armleocpu_regfile_clear_fsm: owns state, clear_cnt and busy, and outputs the clear write address/enable.
- Storage array and read muxing stay in the top.

Test Plan:
- Reset release, REG_COUNT=32: busy=1 for exactly 32 cycles after rst falls. Then all 32 reads return 0 and busy=0.
- Write x5=0xDEADBEEF with rs_addr0=5, BYPASS=1: rs_rdata0=0xDEADBEEF in the same cycle. With BYPASS=0: old value that cycle, 0xDEADBEEF next cycle.
- Write x0=0x12345678 with ZERO_REG=1: reads of x0 return 0 in the same and later cycles. With ZERO_REG=0: reads return 0x12345678.
- READY with x3=0xA5A5A5A5, pulse clear_req: busy=1 for 32 cycles. A write to x7 during that time is dropped. Afterwards x3=0 and x7=0.
- Assert rst at clear cycle 10, release: busy stays 1 for a full 32 cycles after release.
- PARITY_EN: write x9=0x1 with rd_parity_flip=1, read x9 -> rs_parity_err[0]=1. Rewrite with flip=0 -> err=0. Same-cycle bypassed read -> err=0.

Source files
------------

// File: rtl/armleocpu_regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Parity support is built only when ARMLEOCPU_REGFILE_PARITY_EN is defined.
package armleocpu_regfile_pkg;

  typedef enum logic [0:0] {
    STATE_CLEAR = 1'b0,
    STATE_READY = 1'b1
  } state_t;

  // Widest entry the parity helper accepts; narrower data is zero-extended.
  localparam int PARITY_MAX_W = 128;

  function automatic int calc_aw(input int count);
    if (count <= 2) begin
      return 1;
    end else begin
      return $clog2(count);
    end
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/armleocpu_regfile_clear_fsm.sv
// Sequential clear engine: walks every entry once after reset or on request,
// holding busy high until the last entry has been zeroed.
module armleocpu_regfile_clear_fsm
  import armleocpu_regfile_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int AW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_en
);

  localparam logic [AW-1:0] LAST = AW'(REG_COUNT - 1);

  state_t          state_r;
  logic [AW-1:0]   cnt_r;
  logic            busy_r;

  // Clear sequencing; busy drops on the same edge that zeroes the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= STATE_CLEAR;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        STATE_CLEAR: begin
          if (cnt_r == LAST) begin
            state_r <= STATE_READY;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + AW'(1);
          end
        end
        STATE_READY: begin
          if (clear_req) begin
            state_r <= STATE_CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= STATE_CLEAR;
          cnt_r   <= '0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign clr_en   = busy_r;
  assign clr_addr = cnt_r;

endmodule

// File: rtl/armleocpu_regfile_mp.sv
// Parametrised multi-read-port register file with bypass, hardwired zero and
// a clear engine. Optional parity via ARMLEOCPU_REGFILE_PARITY_EN.
module armleocpu_regfile_mp
  import armleocpu_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  localparam int AW        = calc_aw(REG_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_req,
  output logic                             busy,
  input  logic [READ_PORTS*AW-1:0]         rs_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rs_rdata,
  input  logic [AW-1:0]                    rd_addr,
  input  logic [DATA_WIDTH-1:0]            rd_wdata,
  input  logic                             rd_write
`ifdef ARMLEOCPU_REGFILE_PARITY_EN
  ,
  input  logic                             rd_parity_flip,
  output logic [READ_PORTS-1:0]            rs_parity_err
`endif
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [AW-1:0]         clr_addr_s;
  logic                  clr_en_s;
  logic                  wr_zero_s;
  logic                  wr_en_s;

  armleocpu_regfile_clear_fsm #(
    .REG_COUNT (REG_COUNT),
    .AW        (AW)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_addr  (clr_addr_s),
    .clr_en    (clr_en_s)
  );

  assign wr_zero_s = (ZERO_REG != 0) && (rd_addr == '0);
  assign wr_en_s   = rd_write && !busy && !wr_zero_s;

  // Storage: the clear engine owns the array while busy, writeback otherwise.
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      regs[clr_addr_s] <= '0;
    end else if (wr_en_s) begin
      regs[rd_addr] <= rd_wdata;
    end
  end

`ifdef ARMLEOCPU_REGFILE_PARITY_EN
  logic par_r [REG_COUNT];

  function automatic logic [PARITY_MAX_W-1:0] widen(input logic [DATA_WIDTH-1:0] d);
    logic [PARITY_MAX_W-1:0] w;
    w = '0;
    w[DATA_WIDTH-1:0] = d;
    return w;
  endfunction

  // Parity shadow; flip lets a test plant a single corrupted entry.
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      par_r[clr_addr_s] <= 1'b0;
    end else if (wr_en_s) begin
      par_r[rd_addr] <= even_parity(widen(rd_wdata)) ^ rd_parity_flip;
    end
  end
`endif

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
    logic [AW-1:0]         addr_s;
    logic                  zero_s;
    logic                  byp_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign addr_s = rs_addr[k*AW +: AW];

    // Read priority: busy, hardwired zero, same-cycle write, stored value.
    always_comb begin
      zero_s = (ZERO_REG != 0) && (addr_s == '0);
      byp_s  = (BYPASS != 0) && rd_write && (rd_addr == addr_s);
      if (busy) begin
        data_s = '0;
      end else if (zero_s) begin
        data_s = '0;
      end else if (byp_s) begin
        data_s = rd_wdata;
      end else begin
        data_s = regs[addr_s];
      end
    end

    assign rs_rdata[k*DATA_WIDTH +: DATA_WIDTH] = data_s;

`ifdef ARMLEOCPU_REGFILE_PARITY_EN
    assign rs_parity_err[k] = !busy && !zero_s && !byp_s &&
                              (par_r[addr_s] != even_parity(widen(regs[addr_s])));
`endif
  end

endmodule

// File: tb/tb_armleocpu_regfile_mp.sv
// Directed bench: one instance with bypass+zero-reg, one with both disabled.
module tb_armleocpu_regfile_mp;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int RP = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_req;
  logic [RP*AW-1:0]  rs_addr;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_wdata;
  logic              rd_write;
  logic              busy_a, busy_b;
  logic [RP*DW-1:0]  rdata_a, rdata_b;
`ifdef ARMLEOCPU_REGFILE_PARITY_EN
  logic              rd_parity_flip;
  logic [RP-1:0]     perr_a, perr_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  armleocpu_regfile_mp #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_a),
    .rs_addr(rs_addr), .rs_rdata(rdata_a),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_write(rd_write)
`ifdef ARMLEOCPU_REGFILE_PARITY_EN
    , .rd_parity_flip(rd_parity_flip), .rs_parity_err(perr_a)
`endif
  );

  armleocpu_regfile_mp #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP), .BYPASS(0), .ZERO_REG(0)
  ) dut_b (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_b),
    .rs_addr(rs_addr), .rs_rdata(rdata_b),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_write(rd_write)
`ifdef ARMLEOCPU_REGFILE_PARITY_EN
    , .rd_parity_flip(rd_parity_flip), .rs_parity_err(perr_b)
`endif
  );

  task automatic test_reset();
    int n;
    rst = 1'b1; clear_req = 1'b0; rd_write = 1'b0; rd_addr = 5'd0;
    rd_wdata = 32'h0; rs_addr = 10'd0;
`ifdef ARMLEOCPU_REGFILE_PARITY_EN
    rd_parity_flip = 1'b0;
`endif
    #12;
    vectors++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy got a=%b b=%b exp 1", busy_a, busy_b);
    end
    vectors++;
    if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
      miscompares++; $display("FAIL reset_rdata got a=%h b=%h exp 0", rdata_a, rdata_b);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n !== 32) begin
      miscompares++; $display("FAIL reset_clear_cycles got %0d exp 32", n);
    end
    vectors++;
    if (busy_b !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy_b_end got %b exp 0", busy_b);
    end
    for (int i = 0; i < RC; i++) begin
      logic [AW-1:0] ai;
      ai = AW'(i);
      rs_addr = {ai, ai};
      #1;
      vectors++;
      if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
        miscompares++; $display("FAIL reset_read_x%0d got a=%h b=%h exp 0", i, rdata_a, rdata_b);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    rd_write = 1'b1; rd_addr = 5'd5; rd_wdata = 32'hDEADBEEF; rs_addr = {5'd5, 5'd5};
    #1;
    vectors++;
    if (rdata_a !== 64'hDEADBEEF_DEADBEEF) begin
      miscompares++; $display("FAIL bypass_same_cycle got %h exp deadbeefdeadbeef", rdata_a);
    end
    vectors++;
    if (rdata_b !== 64'h0) begin
      miscompares++; $display("FAIL nobypass_old_value got %h exp 0", rdata_b);
    end
    @(posedge clk); #1;
    rd_write = 1'b0;
    #1;
    vectors++;
    if (rdata_a !== 64'hDEADBEEF_DEADBEEF || rdata_b !== 64'hDEADBEEF_DEADBEEF) begin
      miscompares++; $display("FAIL bypass_after_edge got a=%h b=%h exp deadbeefdeadbeef", rdata_a, rdata_b);
    end
    // Write x6 while port0 reads x5 and port1 reads x6.
    @(negedge clk);
    rd_write = 1'b1; rd_addr = 5'd6; rd_wdata = 32'hCAFEF00D; rs_addr = {5'd6, 5'd5};
    #1;
    vectors++;
    if (rdata_a !== 64'hCAFEF00D_DEADBEEF || rdata_b !== 64'h00000000_DEADBEEF) begin
      miscompares++; $display("FAIL bypass_mixed_ports got a=%h b=%h exp cafef00ddeadbeef/00000000deadbeef", rdata_a, rdata_b);
    end
    @(posedge clk); #1;
    rd_write = 1'b0;
    #1;
    vectors++;
    if (rdata_b !== 64'hCAFEF00D_DEADBEEF) begin
      miscompares++; $display("FAIL nobypass_mixed_next got %h exp cafef00ddeadbeef", rdata_b);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    rd_write = 1'b1; rd_addr = 5'd0; rd_wdata = 32'h12345678; rs_addr = {5'd0, 5'd0};
    #1;
    vectors++;
    if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
      miscompares++; $display("FAIL zero_same_cycle got a=%h b=%h exp 0", rdata_a, rdata_b);
    end
    @(posedge clk); #1;
    rd_write = 1'b0;
    #1;
    vectors++;
    if (rdata_a !== 64'h0) begin
      miscompares++; $display("FAIL zero_reg_after got %h exp 0", rdata_a);
    end
    vectors++;
    if (rdata_b !== 64'h12345678_12345678) begin
      miscompares++; $display("FAIL nozero_reg_after got %h exp 1234567812345678", rdata_b);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rd_write = 1'b1; rd_addr = 5'd10; rd_wdata = 32'h00000001; rs_addr = {5'd11, 5'd10};
    @(posedge clk); #1;
    rd_addr = 5'd11; rd_wdata = 32'h00000002;
    #1;
    vectors++;
    if (rdata_a !== 64'h00000002_00000001 || rdata_b !== 64'h00000000_00000001) begin
      miscompares++; $display("FAIL b2b_second_cycle got a=%h b=%h exp 0000000200000001/0000000000000001", rdata_a, rdata_b);
    end
    @(posedge clk); #1;
    rd_write = 1'b0;
    #1;
    vectors++;
    if (rdata_b !== 64'h00000002_00000001) begin
      miscompares++; $display("FAIL b2b_final got %h exp 0000000200000001", rdata_b);
    end
  endtask

  task automatic test_clear_req();
    int n;
    @(negedge clk);
    rd_write = 1'b1; rd_addr = 5'd3; rd_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rd_write = 1'b0; rs_addr = {5'd3, 5'd3};
    #1;
    vectors++;
    if (rdata_a !== 64'hA5A5A5A5_A5A5A5A5 || rdata_b !== 64'hA5A5A5A5_A5A5A5A5) begin
      miscompares++; $display("FAIL clear_pre_x3 got a=%h b=%h exp a5a5a5a5a5a5a5a5", rdata_a, rdata_b);
    end
    clear_req = 1'b1;
    #1;
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++; $display("FAIL clear_req_not_yet_busy got %b exp 0", busy_a);
    end
    @(posedge clk); #1;
    clear_req = 1'b0;
    vectors++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || rdata_a !== 64'h0) begin
      miscompares++; $display("FAIL clear_started got busy=%b rdata=%h exp busy 1 rdata 0", busy_a, rdata_a);
    end
    n = 0;
    while (busy_a && n < 100) begin
      rd_write  = (n == 20);
      rd_addr   = 5'd7;
      rd_wdata  = 32'h77777777;
      clear_req = (n == 5);
      @(posedge clk); #1; n++;
    end
    rd_write = 1'b0; clear_req = 1'b0;
    vectors++;
    if (n !== 32) begin
      miscompares++; $display("FAIL clear_req_cycles got %0d exp 32", n);
    end
    rs_addr = {5'd7, 5'd3};
    #1;
    vectors++;
    if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
      miscompares++; $display("FAIL clear_post_x3_x7 got a=%h b=%h exp 0", rdata_a, rdata_b);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy_a !== 1'b1 || rdata_a !== 64'h0) begin
      miscompares++; $display("FAIL midreset_state got busy=%b rdata=%h exp 1/0", busy_a, rdata_a);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n !== 32) begin
      miscompares++; $display("FAIL midreset_cycles got %0d exp 32", n);
    end
  endtask

`ifdef ARMLEOCPU_REGFILE_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    rd_write = 1'b1; rd_addr = 5'd9; rd_wdata = 32'h00000001; rd_parity_flip = 1'b1;
    rs_addr = {5'd9, 5'd9};
    #1;
    vectors++;
    if (perr_a !== 2'b00) begin
      miscompares++; $display("FAIL parity_bypass got %b exp 00", perr_a);
    end
    @(posedge clk); #1;
    rd_write = 1'b0; rd_parity_flip = 1'b0;
    #1;
    vectors++;
    if (perr_a !== 2'b11 || perr_b !== 2'b11) begin
      miscompares++; $display("FAIL parity_flip_err got a=%b b=%b exp 11", perr_a, perr_b);
    end
    @(negedge clk);
    rd_write = 1'b1;
    @(posedge clk); #1;
    rd_write = 1'b0;
    #1;
    vectors++;
    if (perr_a !== 2'b00 || perr_b !== 2'b00) begin
      miscompares++; $display("FAIL parity_clean got a=%b b=%b exp 00", perr_a, perr_b);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_clear();
`ifdef ARMLEOCPU_REGFILE_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
